// File: rtl/sdram_bus_responder_if.sv
// Strobe bus between the SDRAM test initiator (master) and the memory-side responder (slave).
interface sdram_bus_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              err;
  logic [15:0]       req_cnt;

  modport master (
    output write, read, address, writedata,
    input  waitrequest, readdata, readdatavalid, err, req_cnt
  );

  modport slave (
    input  write, read, address, writedata,
    output waitrequest, readdata, readdatavalid, err, req_cnt
  );
endinterface

// File: rtl/sdram_bus_responder.sv
// SDRAM controller stand-in: on-chip storage, fixed read latency with pipelined reads,
// and periodic refresh stalls reported on waitrequest.
module sdram_bus_responder #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 16,
  parameter int RD_LAT         = 3,
  parameter int REFRESH_PERIOD = 780,
  parameter int REFRESH_CYCLES = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_bus_responder_if.slave bus
);

  localparam int RC_W = $clog2(REFRESH_PERIOD);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {S_NORMAL, S_DRAIN, S_REFRESH} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]             mem [0:2**ADDR_W-1];
  logic [RD_LAT-1:0][DATA_W-1:0] dat_pipe;
  logic [RD_LAT:0]               vld_pipe;
  logic [RC_W-1:0]               ref_cnt;
  logic [RF_W-1:0]               rf_cnt;
  logic                          ref_tc, refresh_pending;
  logic                          acc_wr, acc_rd, acc;

  // A write and read together perform only the write; the read is dropped.
  assign acc    = (bus.write | bus.read) & ~bus.waitrequest;
  assign acc_wr = bus.write & ~bus.waitrequest;
  assign acc_rd = bus.read & ~bus.write & ~bus.waitrequest;
  assign ref_tc = (ref_cnt == RC_W'(REFRESH_PERIOD - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_NORMAL;
    else        state <= state_nxt;
  end

  // Next-state logic: drain in-flight reads before refreshing.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NORMAL:  if (refresh_pending) state_nxt = S_DRAIN;
      S_DRAIN:   if (vld_pipe == '0) state_nxt = S_REFRESH;
      S_REFRESH: if (rf_cnt == RF_W'(REFRESH_CYCLES - 1)) state_nxt = S_NORMAL;
      default:   state_nxt = S_NORMAL;
    endcase
  end

  // Outputs from state: waitrequest comes straight off the state flops.
  always_comb begin
    bus.waitrequest = (state != S_NORMAL);
  end

  // Free-running refresh interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt <= '0;
    else        ref_cnt <= ref_tc ? '0 : ref_cnt + RC_W'(1);
  end

  // Pending flag: an expiry always wins so one landing during a stall is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           refresh_pending <= 1'b0;
    else if (ref_tc)                                      refresh_pending <= 1'b1;
    else if (state == S_DRAIN && state_nxt == S_REFRESH)  refresh_pending <= 1'b0;
  end

  // Counts cycles spent in REFRESH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rf_cnt <= '0;
    else if (state == S_REFRESH) rf_cnt <= rf_cnt + RF_W'(1);
    else                         rf_cnt <= '0;
  end

  // Storage and synchronous read; data stages carry no reset, validity is tracked separately.
  // A write lands at its edge, so a read one cycle later already sees it.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[bus.address] <= bus.writedata;
    dat_pipe[0] <= mem[bus.address];
    for (int k = 1; k < RD_LAT; k++) dat_pipe[k] <= dat_pipe[k-1];
  end

  // Read valid shift register; the last stage is the response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[RD_LAT-1:0], acc_rd};
  end

  assign bus.readdatavalid = vld_pipe[RD_LAT];

  // Read data register holds its value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  bus.readdata <= '0;
    else if (vld_pipe[RD_LAT-1]) bus.readdata <= dat_pipe[RD_LAT-1];
  end

  // Sticky collision flag and accepted-request counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err     <= 1'b0;
      bus.req_cnt <= '0;
    end else begin
      if (acc_wr & bus.read) bus.err <= 1'b1;
      if (acc)               bus.req_cnt <= bus.req_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_bus_responder.sv
// Directed bench for sdram_bus_responder: vector table plus refresh, collision and reset sequences.
module tb_sdram_bus_responder;

  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int LAT = 3;
  localparam int RP  = 100;
  localparam int RC  = 8;
  localparam int NV  = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdram_bus_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_bus_responder #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];

  // Response monitor: each expected read must pulse exactly on its due cycle, nothing else may.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("rd_valid", bus.readdatavalid, 1);
        check("rd_data", bus.readdata, q[0].data);
        void'(q.pop_front());
      end else if (bus.readdatavalid) begin
        check("unexpected_valid", bus.readdatavalid, 0);
      end
    end
  end

  // Present a request and hold it until accepted; called at a negedge, returns at the next one
  // after the accepting edge.
  task automatic drive(bit we, bit re, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] exp);
    int tries = 0;
    bus.write = we; bus.read = re; bus.address = a; bus.writedata = d;
    while (bus.waitrequest && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) check("accept_timeout", bus.waitrequest, 0);
    else if (re && !we) q.push_back('{exp, cyc + 1 + LAT});
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

  task automatic idle(int n);
    bus.write = 1'b0; bus.read = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit            we;
    bit            re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
    int            gap;
  } vec_t;
  vec_t tbl[NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, high, r1, r2, cnt0;

    tbl[0]  = '{1, 0, 10'h005, 16'hBEEF, 16'h0000, 0};
    tbl[1]  = '{0, 1, 10'h005, 16'h0000, 16'hBEEF, 5};
    tbl[2]  = '{1, 0, 10'h010, 16'h1234, 16'h0000, 0};
    tbl[3]  = '{0, 1, 10'h010, 16'h0000, 16'h1234, 5};
    tbl[4]  = '{1, 0, 10'h000, 16'h00A0, 16'h0000, 0};
    tbl[5]  = '{1, 0, 10'h001, 16'h00A1, 16'h0000, 0};
    tbl[6]  = '{1, 0, 10'h002, 16'h00A2, 16'h0000, 0};
    tbl[7]  = '{1, 0, 10'h003, 16'h00A3, 16'h0000, 0};
    tbl[8]  = '{0, 1, 10'h000, 16'h0000, 16'h00A0, 0};
    tbl[9]  = '{0, 1, 10'h001, 16'h0000, 16'h00A1, 0};
    tbl[10] = '{0, 1, 10'h002, 16'h0000, 16'h00A2, 0};
    tbl[11] = '{0, 1, 10'h003, 16'h0000, 16'h00A3, 5};
    tbl[12] = '{1, 0, 10'h3FF, 16'hFFFF, 16'h0000, 0};
    tbl[13] = '{0, 1, 10'h3FF, 16'h0000, 16'hFFFF, 5};

    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_waitrequest", bus.waitrequest, 0);
    check("rst_valid", bus.readdatavalid, 0);
    check("rst_readdata", bus.readdata, 0);
    check("rst_err", bus.err, 0);
    check("rst_req_cnt", bus.req_cnt, 0);

    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Table: write/read latency, write-then-read hazard, back-to-back reads, top address.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
      idle(tbl[i].gap);
    end
    idle(6);
    check("table_all_returned", q.size(), 0);
    check("table_req_cnt", bus.req_cnt, NV);
    check("table_err", bus.err, 0);

    // Refresh: hold a read while waitrequest is high.
    t = 0;
    while (!bus.waitrequest && t < 3 * RP) begin @(negedge clk); t++; end
    check("refresh_seen", bus.waitrequest, 1);
    r1 = cyc;
    cnt0 = bus.req_cnt;
    bus.read = 1'b1; bus.address = 10'h005;
    high = 0;
    while (bus.waitrequest && high < 50) begin high++; @(negedge clk); end
    check("wait_cycles", high, 1 + RC);
    check("no_accept_in_wait", bus.req_cnt, cnt0);
    drive(0, 1, 10'h005, 16'h0000, 16'hBEEF);
    check("held_read_req_cnt", bus.req_cnt, cnt0 + 1);
    idle(6);
    check("held_read_returned", q.size(), 0);

    // Next refresh comes exactly one period later.
    t = 0;
    while (!bus.waitrequest && t < 3 * RP) begin @(negedge clk); t++; end
    r2 = cyc;
    check("refresh_period", r2 - r1, RP);
    t = 0;
    while (bus.waitrequest && t < 50) begin @(negedge clk); t++; end
    check("refresh_release", bus.waitrequest, 0);

    // Collision: write wins, no read response, sticky error.
    cnt0 = bus.req_cnt;
    drive(1, 1, 10'h020, 16'h55AA, 16'h0000);
    check("collision_err", bus.err, 1);
    check("collision_req_cnt", bus.req_cnt, cnt0 + 1);
    idle(6);
    drive(0, 1, 10'h020, 16'h0000, 16'h55AA);
    idle(6);
    check("collision_data_returned", q.size(), 0);
    check("err_sticky", bus.err, 1);

    // Reset with two reads in flight: no responses survive.
    drive(0, 1, 10'h000, 16'h0000, 16'h00A0);
    drive(0, 1, 10'h001, 16'h0000, 16'h00A1);
    q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.readdatavalid, 0);
    check("midrst_readdata", bus.readdata, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_waitrequest", bus.waitrequest, 0);
    check("midrst_req_cnt", bus.req_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("post_rst_req_cnt", bus.req_cnt, 0);
    check("post_rst_err", bus.err, 0);
    check("post_rst_readdata", bus.readdata, 0);

    // Storage survives reset.
    drive(0, 1, 10'h3FF, 16'h0000, 16'hFFFF);
    idle(6);
    check("final_returned", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
